// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - UART, sampler, sender and sample-memory control bundle for capture_sequencer
interface capture_sequencer_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int DEPTH        = 256
);
   localparam int CH_W = $clog2(NUM_CHANNELS);
   localparam int AW   = $clog2(DEPTH);

   logic            iRxDone;
   logic [7:0]      iRxData;
   logic            iSamplingDone;
   logic            iSendingDone;
   logic            oFetchValue;
   logic            oInsertValue;
   logic            oResetSerial;
   logic            oStartSampling;
   logic            oStartSending;
   logic            oMemWrite;
   logic            oMemSel;
   logic [AW-1:0]   oSampleAddr;
   logic [CH_W-1:0] oChannel;
   logic            oBusy;
   logic            oError;
   logic [1:0]      oErrorCode;

   modport master (
      input  iRxDone, iRxData, iSamplingDone, iSendingDone,
      output oFetchValue, oInsertValue, oResetSerial, oStartSampling, oStartSending,
             oMemWrite, oMemSel, oSampleAddr, oChannel, oBusy, oError, oErrorCode
   );

   modport slave (
      output iRxDone, iRxData, iSamplingDone, iSendingDone,
      input  oFetchValue, oInsertValue, oResetSerial, oStartSampling, oStartSending,
             oMemWrite, oMemSel, oSampleAddr, oChannel, oBusy, oError, oErrorCode
   );
endinterface

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - Multi-channel capture controller: command fetch, sample capture, stream-back
module capture_sequencer #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DEPTH          = 256,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic                 iClock,
   input logic                 iReset,
   capture_sequencer_if.master bus
);
   localparam int CH_W = $clog2(NUM_CHANNELS);
   localparam int AW   = $clog2(DEPTH);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    NUM_CH8    = 8'(NUM_CHANNELS);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_CHANNEL  = 2'b11;

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      FETCH          = 3'd1,
      START_SAMPLING = 3'd2,
      SAMPLING       = 3'd3,
      START_SENDING  = 3'd4,
      SENDING        = 3'd5,
      NEXT_CHANNEL   = 3'd6,
      ERROR          = 3'd7
   } stateType;

   stateType        state;
   stateType        nextState;

   logic            sweepMode;
   logic [CH_W-1:0] startChannel;
   logic [CH_W-1:0] channel;
   logic [AW-1:0]   sampleAddr;
   logic [TW-1:0]   timeoutCount;
   logic [1:0]      errorCode;

   logic            startInvalid;
   logic            moreChannels;
   logic            sampleFull;
   logic            sendExpired;
   logic            unusedRxBits;

   logic            fetchValue;
   logic            insertValue;
   logic            resetSerial;
   logic            startSampling;
   logic            startSending;
   logic            memWrite;
   logic            memSel;
   logic            busy;
   logic            errorPulse;

   // Channel comparisons widened to 8 bits so NUM_CHANNELS=128 still fits.
   assign startInvalid = 8'(startChannel) >= NUM_CH8;
   assign moreChannels = 8'(channel) < (NUM_CH8 - 8'd1);
   assign sampleFull   = (sampleAddr == LAST_ADDR);
   assign sendExpired  = (timeoutCount == LAST_COUNT);
   assign unusedRxBits = ^bus.iRxData;

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState     = state;
      fetchValue    = 1'b0;
      insertValue   = 1'b0;
      resetSerial   = 1'b0;
      startSampling = 1'b0;
      startSending  = 1'b0;
      memWrite      = 1'b0;
      memSel        = 1'b0;
      busy          = 1'b1;
      errorPulse    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.iRxDone) begin
               nextState = FETCH;
            end
         end
         FETCH: begin
            fetchValue = 1'b1;
            nextState  = startInvalid ? ERROR : START_SAMPLING;
         end
         START_SAMPLING: begin
            startSampling = 1'b1;
            resetSerial   = 1'b1;
            insertValue   = 1'b1;
            nextState     = SAMPLING;
         end
         SAMPLING: begin
            memWrite = 1'b1;
            // Completion wins over a full buffer on the last address.
            if (bus.iSamplingDone) begin
               nextState = START_SENDING;
            end else if (sampleFull) begin
               nextState = ERROR;
            end
         end
         START_SENDING: begin
            startSending = 1'b1;
            memSel       = 1'b1;
            nextState    = SENDING;
         end
         SENDING: begin
            memSel = 1'b1;
            if (bus.iSendingDone) begin
               nextState = (sweepMode && moreChannels) ? NEXT_CHANNEL : IDLE;
            end else if (sendExpired) begin
               nextState = ERROR;
            end
         end
         NEXT_CHANNEL: begin
            nextState = START_SAMPLING;
         end
         ERROR: begin
            errorPulse = 1'b1;
            nextState  = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         sweepMode    <= 1'b0;
         startChannel <= '0;
         channel      <= '0;
         sampleAddr   <= '0;
         timeoutCount <= '0;
         errorCode    <= ERR_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.iRxDone) begin
                  sweepMode    <= bus.iRxData[7];
                  startChannel <= bus.iRxData[CH_W-1:0];
               end
            end
            FETCH: begin
               errorCode <= startInvalid ? ERR_CHANNEL : ERR_NONE;
               if (!startInvalid) begin
                  channel <= startChannel;
               end
            end
            START_SAMPLING: begin
               sampleAddr <= '0;
            end
            SAMPLING: begin
               // Saturate at the last word so an overflow leaves the address at DEPTH-1.
               if (!sampleFull) begin
                  sampleAddr <= sampleAddr + 1'b1;
               end
               if (!bus.iSamplingDone && sampleFull) begin
                  errorCode <= ERR_OVERFLOW;
               end
            end
            START_SENDING: begin
               timeoutCount <= '0;
            end
            SENDING: begin
               timeoutCount <= timeoutCount + 1'b1;
               if (!bus.iSendingDone && sendExpired) begin
                  errorCode <= ERR_TIMEOUT;
               end
            end
            NEXT_CHANNEL: begin
               channel <= channel + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.oFetchValue    = fetchValue;
   assign bus.oInsertValue   = insertValue;
   assign bus.oResetSerial   = resetSerial;
   assign bus.oStartSampling = startSampling;
   assign bus.oStartSending  = startSending;
   assign bus.oMemWrite      = memWrite;
   assign bus.oMemSel        = memSel;
   assign bus.oSampleAddr    = sampleAddr;
   assign bus.oChannel       = channel;
   assign bus.oBusy          = busy;
   assign bus.oError         = errorPulse;
   assign bus.oErrorCode     = errorCode;
endmodule
